// File: rtl/seq_logic_unit.sv
// seq_logic_unit
//   Bit-serial logic unit. A started operation walks the captured operands
//   SLICE bits per cycle, LSB slice first, applying AND/OR/XOR/NOR. After
//   K = WIDTH/SLICE RUN cycles the assembled result is published on out.
//
// Parameters
//   WIDTH  operand/result width (must be a multiple of SLICE)
//   SLICE  bits processed per RUN cycle
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request a new operation (honoured in IDLE or DONE only)
//   op     00 AND, 01 OR, 10 XOR, 11 NOR
//   InpA   operand A
//   InpB   operand B
//   busy   high while in RUN
//   done   one-cycle pulse while in DONE (result just written to out)
//   out    registered result of the last completed operation
//   zero   registered, high when out == 0
//   parity XOR-reduction of out (only with SEQ_LOGIC_UNIT_PARITY_EN defined)
//
// Build option
//   SEQ_LOGIC_UNIT_PARITY_EN  adds the parity output and its register.
module seq_logic_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] InpA,
  input  logic [WIDTH-1:0] InpB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int K     = WIDTH / SLICE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               load, finish;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, res, res_nxt;
  logic [SLICE-1:0]   slice_res;

  function automatic logic [SLICE-1:0] logic_op(input logic [1:0] o,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // Operands are shifted right each RUN cycle, so the active slice is
  // always the low SLICE bits. The result fills from the top, so after K
  // shifts the first slice computed lands at bit 0.
  assign slice_res = logic_op(op_q, a_q[SLICE-1:0], b_q[SLICE-1:0]);
  assign res_nxt   = (res >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(K - 1)) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res    <= '0;
      out    <= '0;
      zero   <= 1'b1;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        a_q  <= InpA;
        b_q  <= InpB;
        op_q <= op;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_q <= a_q >> SLICE;
        b_q <= b_q >> SLICE;
        res <= res_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      // out/zero/parity move only on the RUN->DONE transition.
      if (finish) begin
        out    <= res_nxt;
        zero   <= (res_nxt == '0);
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
        parity <= ^res_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

  localparam int K  = 4;
  localparam int K5 = 5;

  logic       clk = 1'b0;
  logic       rst, start, start5;
  logic [1:0] op, op5;
  logic [7:0] inpa, inpb, out;
  logic [4:0] a5, b5, out5;
  logic       busy, done, zero, busy5, done5, zero5;
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
  logic       parity, parity5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .InpA(inpa), .InpB(inpb),
    .busy(busy), .done(done), .out(out), .zero(zero)
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    , .parity(parity)
`endif
  );

  seq_logic_unit #(.WIDTH(5), .SLICE(1)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .op(op5), .InpA(a5), .InpB(b5),
    .busy(busy5), .done(done5), .out(out5), .zero(zero5)
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    , .parity(parity5)
`endif
  );

  // Whole-word reference: each result bit is op applied to the same bit of A and B.
  function automatic logic [7:0] model8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic [4:0] model5(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; inpa = a; inpb = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles until done (bounded), noting any non-busy cycle or out change.
  task automatic wait_done(output int n, output bit gap, output bit chg);
    logic [7:0] prev;
    prev = out; n = 0; gap = 0; chg = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) gap = 1;
      if (out !== prev) chg = 1;
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b out=%h zero=%b, want 0 0 00 1", busy, done, out, zero);
    end
    checks++;
    if (busy5 !== 1'b0 || done5 !== 1'b0 || out5 !== 5'h00 || zero5 !== 1'b1) begin
      errors++;
      $display("FAIL reset5: busy=%b done=%b out=%h zero=%b, want 0 0 00 1", busy5, done5, out5, zero5);
    end
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    checks++;
    if (parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity: got %b want 0", parity);
    end
`endif
  endtask

  task automatic test_xor;
    int n; bit gap, chg;
    start_op(2'b10, 8'h12, 8'hE5);
    wait_done(n, gap, chg);
    checks++;
    if (n !== K || gap !== 1'b0 || chg !== 1'b0) begin
      errors++;
      $display("FAIL xor_timing: latency=%0d gap=%b outchg=%b, want %0d 0 0", n, gap, chg, K);
    end
    checks++;
    if (out !== 8'hF7 || zero !== 1'b0) begin
      errors++;
      $display("FAIL xor_result: out=%h zero=%b, want F7 0", out, zero);
    end
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    checks++;
    if (parity !== 1'b1) begin
      errors++;
      $display("FAIL xor_parity: got %b want 1", parity);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b after DONE, want 0 0", done, busy);
    end
  endtask

  task automatic test_ignore_inputs;
    int n, pulses; bit gap, chg;
    start_op(2'b00, 8'hF0, 8'h3C);
    inpa = 8'hFF; op = 2'b01; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done(n, gap, chg);
    checks++;
    if (n !== K - 2 || gap !== 1'b0) begin
      errors++;
      $display("FAIL ignore_timing: remaining=%0d gap=%b, want %0d 0", n, gap, K - 2);
    end
    checks++;
    if (out !== 8'h30) begin
      errors++;
      $display("FAIL ignore_result: out=%h want 30", out);
    end
    pulses = 0;
    for (int i = 0; i < K + 3; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL single_done: extra busy/done cycles=%0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit gap, chg;
    start_op(2'b11, 8'hFF, 8'h00);
    wait_done(n, gap, chg);
    checks++;
    if (n !== K || out !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL nor_result: latency=%0d out=%h zero=%b, want %0d 00 1", n, out, zero, K);
    end
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
    checks++;
    if (parity !== 1'b0) begin
      errors++;
      $display("FAIL nor_parity: got %b want 0", parity);
    end
`endif
    start_op(2'b01, 8'h0F, 8'hA0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run: busy=%b want 1 right after DONE", busy);
    end
    wait_done(n, gap, chg);
    checks++;
    if (n + 1 !== K + 1 || out !== 8'hAF || zero !== 1'b0 || chg !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: period=%0d out=%h zero=%b outchg=%b, want %0d AF 0 0", n + 1, out, zero, chg, K + 1);
    end
    tick();
  endtask

  task automatic test_reset_midrun;
    int pulses;
    start_op(2'b01, 8'h55, 8'hAA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b out=%h zero=%b, want 0 0 00 1", busy, done, out, zero);
    end
    pulses = 0;
    for (int i = 0; i < K + 3; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: busy/done cycles=%0d want 0", pulses);
    end
  endtask

  task automatic test_start_with_reset;
    op = 2'b10; inpa = 8'hAA; inpb = 8'h0F;
    start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_rst: busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out !== 8'h00) begin
      errors++;
      $display("FAIL start_rst_idle: busy=%b out=%h want 0 00", busy, out);
    end
  endtask

  task automatic test_random;
    int n; bit gap, chg;
    logic [1:0] o; logic [7:0] a, b, exp;
    for (int it = 0; it < 25; it++) begin
      o = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      exp = model8(o, a, b);
      start_op(o, a, b);
      wait_done(n, gap, chg);
      checks++;
      if (n !== K || gap !== 1'b0 || chg !== 1'b0 || out !== exp || zero !== (exp == 8'h00)) begin
        errors++;
        $display("FAIL rand%0d: op=%0d a=%h b=%h lat=%0d gap=%b chg=%b out=%h zero=%b, want lat=%0d out=%h zero=%b",
                 it, o, a, b, n, gap, chg, out, zero, K, exp, (exp == 8'h00));
      end
`ifdef SEQ_LOGIC_UNIT_PARITY_EN
      checks++;
      if (parity !== ^exp) begin
        errors++;
        $display("FAIL rand_parity%0d: got %b want %b", it, parity, ^exp);
      end
`endif
      // Half the time start the next op straight from DONE; otherwise drop to IDLE.
      if ($urandom_range(0, 1) == 0) begin
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== exp) begin
          errors++;
          $display("FAIL rand_idle%0d: busy=%b done=%b out=%h, want 0 0 %h", it, busy, done, out, exp);
        end
      end
    end
  endtask

  task automatic test_width5;
    int n;
    logic [1:0] o; logic [4:0] a, b, exp;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        o = 2'b10; a = 5'b10001; b = 5'b01101;
      end else begin
        o = 2'($urandom_range(0, 3)); a = 5'($urandom); b = 5'($urandom);
      end
      exp = model5(o, a, b);
      op5 = o; a5 = a; b5 = b; start5 = 1'b1;
      tick();
      start5 = 1'b0;
      n = 0;
      while (done5 !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n !== K5 || out5 !== exp || zero5 !== (exp == 5'd0)) begin
        errors++;
        $display("FAIL w5_%0d: op=%0d a=%b b=%b lat=%0d out=%b zero=%b, want lat=%0d out=%b", it, o, a, b, n, out5, zero5, K5, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    op = '0; inpa = '0; inpb = '0; op5 = '0; a5 = '0; b5 = '0;
    test_reset();
    test_xor();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_midrun();
    test_start_with_reset();
    test_random();
    test_width5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
